// File: rtl/mmcm_mon_pkg.sv
// Shared state encoding and constants for the MMCM/PLL lock and frequency monitor.
package mmcm_mon_pkg;

   localparam int unsigned STATE_W    = 3;
   localparam int unsigned LOSS_W     = 8;
   localparam int unsigned SYNC_DEPTH = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_PRST   = 3'd1,
      ST_WLOCK  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_MEAS   = 3'd4,
      ST_EVAL   = 3'd5,
      ST_FAIL   = 3'd6
   } state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold the values 0..n.
   function automatic int unsigned bits_for(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mmcm_toggle_counter.sv
// One monitored channel: synchroniser, transition detector and saturating transition counter.
module mmcm_toggle_counter
   import mmcm_mon_pkg::*;
#(
   parameter int unsigned CNT_W = 17
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clear,
   input  logic             enable,
   input  logic             toggle,
   output logic [CNT_W-1:0] count
);

   logic [SYNC_DEPTH-1:0] sync;
   logic                  hist;
   logic                  trans;

   assign trans = sync[SYNC_DEPTH-1] ^ hist;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync  <= '0;
         hist  <= 1'b0;
         count <= '0;
      end else begin
         sync <= {sync[SYNC_DEPTH-2:0], toggle};
         hist <= sync[SYNC_DEPTH-1];
         if (clear) begin
            count <= '0;
         end else if (enable && trans && (count != '1)) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmcm_freq_monitor.sv
// Sequences primitive reset and lock, then measures each divided toggle input over a fixed
// window and flags channels whose transition count is within tolerance of the expected value.
module mmcm_freq_monitor
   import mmcm_mon_pkg::*;
#(
   parameter int unsigned                CHANNELS      = 4,
   parameter int unsigned                WIN_W         = 16,
   parameter int unsigned                CNT_W         = 17,
   parameter logic [CHANNELS*CNT_W-1:0]  EXP_CNT       = {4{17'd32768}},
   parameter int unsigned                TOL           = 8,
   parameter int unsigned                RST_CYCLES    = 16,
   parameter int unsigned                LOCK_TO_W     = 20,
   parameter int unsigned                SETTLE_CYCLES = 1024
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      I_START,
   input  logic                      I_CONT,
   input  logic                      I_LOCKED,
   input  logic [CHANNELS-1:0]       I_TOGGLE,
   output logic                      O_PLL_RST,
   output logic                      O_LOCKED,
   output logic [STATE_W-1:0]        O_STATE,
   output logic                      O_VALID,
   output logic [CHANNELS-1:0]       O_PASS,
   output logic                      O_TIMEOUT,
   output logic [LOSS_W-1:0]         O_LOSS_CNT,
   output logic [CHANNELS*CNT_W-1:0] O_CNT
);

   localparam int unsigned TMR_W = max_u(max_u(WIN_W, LOCK_TO_W),
                                         max_u(bits_for(RST_CYCLES), bits_for(SETTLE_CYCLES)));
   localparam logic [TMR_W-1:0] PRST_LAST   = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'({LOCK_TO_W{1'b1}});
   localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'({WIN_W{1'b1}});
   localparam logic [CNT_W:0]   TOL_V       = (CNT_W + 1)'(TOL);

   state_t                state, next_state;
   logic [TMR_W-1:0]      tmr;
   logic [SYNC_DEPTH-1:0] lock_sync;
   logic                  lock_hist;
   logic                  locked;
   logic                  lost;
   logic                  cnt_clear;
   logic                  cnt_enable;
   logic [CNT_W-1:0]      counts [CHANNELS];
   logic [CHANNELS-1:0]   pass_now;
   logic signed [CNT_W:0] diff;
   logic [CNT_W:0]        mag;

   assign locked     = lock_sync[SYNC_DEPTH-1];
   assign lost       = lock_hist && !locked && ((state == ST_SETTLE) || (state == ST_MEAS));
   assign cnt_clear  = (state == ST_SETTLE);
   assign cnt_enable = (state == ST_MEAS);
   assign O_LOCKED   = locked;
   assign O_STATE    = state;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      mmcm_toggle_counter #(.CNT_W(CNT_W)) u_cnt (
         .CLK    (CLK),
         .RST    (RST),
         .clear  (cnt_clear),
         .enable (cnt_enable),
         .toggle (I_TOGGLE[g]),
         .count  (counts[g])
      );
   end

   always_comb begin
      pass_now = '0;
      diff     = '0;
      mag      = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         diff        = signed'({1'b0, counts[i]}) - signed'({1'b0, EXP_CNT[i*CNT_W +: CNT_W]});
         mag         = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
         pass_now[i] = (mag <= TOL_V);
      end
   end

   // Loss of lock outranks window completion, so it is tested first in SETTLE/MEAS.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:   if (I_CONT || I_START) next_state = ST_PRST;
         ST_PRST:   if (tmr == PRST_LAST) next_state = ST_WLOCK;
         ST_WLOCK: begin
            if (locked)                 next_state = ST_SETTLE;
            else if (tmr == LOCK_LAST)  next_state = ST_FAIL;
         end
         ST_SETTLE: begin
            if (lost)                     next_state = ST_PRST;
            else if (tmr == SETTLE_LAST)  next_state = ST_MEAS;
         end
         ST_MEAS: begin
            if (lost)                  next_state = ST_PRST;
            else if (tmr == WIN_LAST)  next_state = ST_EVAL;
         end
         ST_EVAL:   next_state = I_CONT ? ST_SETTLE : ST_IDLE;
         ST_FAIL:   if (I_START) next_state = ST_PRST;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         tmr        <= '0;
         lock_sync  <= '0;
         lock_hist  <= 1'b0;
         O_PLL_RST  <= 1'b0;
         O_VALID    <= 1'b0;
         O_PASS     <= '0;
         O_TIMEOUT  <= 1'b0;
         O_LOSS_CNT <= '0;
         O_CNT      <= '0;
      end else begin
         state     <= next_state;
         tmr       <= (next_state != state) ? '0 : tmr + 1'b1;
         lock_sync <= {lock_sync[SYNC_DEPTH-2:0], I_LOCKED};
         lock_hist <= locked;
         O_PLL_RST <= (next_state == ST_PRST);
         O_VALID   <= 1'b0;
         if (lost) begin
            if (O_LOSS_CNT != '1) O_LOSS_CNT <= O_LOSS_CNT + 1'b1;
            O_PASS <= '0;
         end
         if (state == ST_EVAL) begin
            O_VALID <= 1'b1;
            O_PASS  <= pass_now;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
               O_CNT[i*CNT_W +: CNT_W] <= counts[i];
            end
         end
         if ((state == ST_WLOCK) && (next_state == ST_FAIL)) begin
            O_VALID   <= 1'b1;
            O_PASS    <= '0;
            O_TIMEOUT <= 1'b1;
         end
      end
   end

endmodule
